// File: rtl/pic_ctrl_param.sv
// Parametrised 8259-style interrupt controller: edge/level capture, masking, fully nested
// priority with optional rotation, normal or auto EOI, and a level-based INTA handshake.
module pic_ctrl_param #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_IRQ-1:0]     irq_in,
  input  logic                   cfg_level,
  input  logic                   cfg_auto_eoi,
  input  logic                   cfg_rotate,
  input  logic [VEC_W-IDX_W-1:0] vector_base,
  input  logic                   mask_we,
  input  logic [NUM_IRQ-1:0]     mask_wdata,
  input  logic                   eoi_valid,
  input  logic                   eoi_specific,
  input  logic [IDX_W-1:0]       eoi_level,
  input  logic                   inta,
  output logic                   int_out,
  output logic                   vector_valid,
  output logic [VEC_W-1:0]       vector,
  output logic [NUM_IRQ-1:0]     mask_q,
  output logic [NUM_IRQ-1:0]     irr_q,
  output logic [NUM_IRQ-1:0]     isr_q
);

  typedef enum logic [1:0] {StIdle, StAck, StHold} state_e;

  state_e             state_q;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [IDX_W-1:0]   prio_low_q;

  logic [NUM_IRQ-1:0] pend;
  logic               cand_found, isr_found, eligible, take;
  logic [IDX_W-1:0]   cand_idx, isr_idx, eoi_idx;
  int                 cand_rank, isr_rank;
  logic [NUM_IRQ-1:0] ack_set, eoi_clr, irr_d, isr_d;
  logic               eoi_hit;

  assign pend = irr_q & ~mask_q;

  // Rank 0 is the line just above prio_low; both IRR and ISR are ranked the same way.
  always_comb begin
    logic [IDX_W-1:0] idx;
    int               j;
    idx        = '0;
    j          = 0;
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_rank  = 0;
    isr_found  = 1'b0;
    isr_idx    = '0;
    isr_rank   = 0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      j = int'(prio_low_q) + 1 + k;
      if (j >= NUM_IRQ) j = j - NUM_IRQ;
      idx = IDX_W'(j);
      if (!cand_found && pend[idx]) begin
        cand_found = 1'b1;
        cand_idx   = idx;
        cand_rank  = k;
      end
      if (!isr_found && isr_q[idx]) begin
        isr_found = 1'b1;
        isr_idx   = idx;
        isr_rank  = k;
      end
    end
  end

  assign eligible = cand_found && (!isr_found || cand_rank < isr_rank);
  assign take     = (state_q == StIdle) && inta && eligible;

  // EOI acts on the ISR as it stood before this cycle's acknowledge.
  always_comb begin
    eoi_clr = '0;
    eoi_idx = '0;
    if (eoi_valid) begin
      if (eoi_specific) begin
        eoi_idx = eoi_level;
        for (int i = 0; i < NUM_IRQ; i++) begin
          if (eoi_level == IDX_W'(i)) eoi_clr[i] = isr_q[i];
        end
      end else if (isr_found) begin
        eoi_idx          = isr_idx;
        eoi_clr[isr_idx] = 1'b1;
      end
    end
  end

  assign eoi_hit = |eoi_clr;

  always_comb begin
    ack_set = '0;
    if (take) ack_set[cand_idx] = 1'b1;
    if (cfg_level) begin
      irr_d = irq_in & ~ack_set;
    end else begin
      irr_d = (irr_q & ~ack_set) | (irq_in & ~irq_prev_q);
    end
    isr_d = (isr_q & ~eoi_clr) | (cfg_auto_eoi ? '0 : ack_set);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      irq_prev_q   <= '0;
      irr_q        <= '0;
      isr_q        <= '0;
      mask_q       <= '0;
      prio_low_q   <= IDX_W'(NUM_IRQ - 1);
      int_out      <= 1'b0;
      vector_valid <= 1'b0;
      vector       <= '0;
    end else begin
      irq_prev_q   <= irq_in;
      irr_q        <= irr_d;
      isr_q        <= isr_d;
      int_out      <= 1'b0;
      vector_valid <= 1'b0;
      if (mask_we) mask_q <= mask_wdata;
      if (eoi_hit && cfg_rotate) prio_low_q <= eoi_idx;
      case (state_q)
        StIdle: begin
          int_out <= eligible && !inta;
          if (inta) begin
            state_q      <= StAck;
            vector_valid <= 1'b1;
            vector       <= {vector_base, eligible ? cand_idx : IDX_W'(NUM_IRQ - 1)};
            if (eligible && cfg_auto_eoi && cfg_rotate) prio_low_q <= cand_idx;
          end
        end
        StAck:   state_q <= StHold;
        StHold:  if (!inta) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_ctrl_param.sv
// Scoreboard bench for pic_ctrl_param: an 8-line and a 16-line instance driven by directed vectors.
module tb_pic_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [7:0] a_irq, a_mask_wdata, a_mask_q, a_irr_q, a_isr_q, a_vector;
  logic       a_level, a_auto, a_rot, a_mask_we, a_eoi_valid, a_eoi_spec, a_inta;
  logic       a_int_out, a_vv;
  logic [2:0] a_eoi_level;
  logic [4:0] a_base;

  logic [15:0] b_irq, b_mask_wdata, b_mask_q, b_irr_q, b_isr_q;
  logic        b_eoi_valid, b_eoi_spec, b_inta, b_int_out, b_vv;
  logic [3:0]  b_eoi_level, b_base;
  logic [7:0]  b_vector;

  pic_ctrl_param #(.NUM_IRQ(8), .VEC_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .irq_in(a_irq), .cfg_level(a_level), .cfg_auto_eoi(a_auto),
    .cfg_rotate(a_rot), .vector_base(a_base), .mask_we(a_mask_we), .mask_wdata(a_mask_wdata),
    .eoi_valid(a_eoi_valid), .eoi_specific(a_eoi_spec), .eoi_level(a_eoi_level),
    .inta(a_inta), .int_out(a_int_out), .vector_valid(a_vv), .vector(a_vector),
    .mask_q(a_mask_q), .irr_q(a_irr_q), .isr_q(a_isr_q)
  );

  pic_ctrl_param #(.NUM_IRQ(16), .VEC_W(8)) u_dut_b (
    .clk(clk), .reset(reset), .irq_in(b_irq), .cfg_level(1'b0), .cfg_auto_eoi(1'b0),
    .cfg_rotate(1'b0), .vector_base(b_base), .mask_we(1'b0), .mask_wdata(b_mask_wdata),
    .eoi_valid(b_eoi_valid), .eoi_specific(b_eoi_spec), .eoi_level(b_eoi_level),
    .inta(b_inta), .int_out(b_int_out), .vector_valid(b_vv), .vector(b_vector),
    .mask_q(b_mask_q), .irr_q(b_irr_q), .isr_q(b_isr_q)
  );

  int         checks = 0;
  int         failures = 0;
  int         vv_a_cnt = 0;
  int         vv_b_cnt = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: every vector strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (a_vv === 1'b1) begin
      vv_a_cnt++;
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL vec_a unexpected: got %0h expected none", a_vector);
      end else begin
        chk("vec_a", 32'(a_vector), 32'(qa.pop_front()));
      end
    end
    if (b_vv === 1'b1) begin
      vv_b_cnt++;
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL vec_b unexpected: got %0h expected none", b_vector);
      end else begin
        chk("vec_b", 32'(b_vector), 32'(qb.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic a_pulse(input logic [7:0] v);
    a_irq = v;
    cyc(1);
    a_irq = 8'h00;
    cyc(1);
  endtask

  task automatic a_ack(input logic [7:0] exp);
    qa.push_back(exp);
    a_inta = 1'b1;
    cyc(1);
    a_inta = 1'b0;
    cyc(3);
  endtask

  task automatic a_eoi(input logic spec, input logic [2:0] lvl);
    a_eoi_valid = 1'b1;
    a_eoi_spec  = spec;
    a_eoi_level = lvl;
    cyc(1);
    a_eoi_valid = 1'b0;
    cyc(1);
  endtask

  task automatic b_pulse(input logic [15:0] v);
    b_irq = v;
    cyc(1);
    b_irq = 16'h0000;
    cyc(1);
  endtask

  task automatic b_ack(input logic [7:0] exp);
    qb.push_back(exp);
    b_inta = 1'b1;
    cyc(1);
    b_inta = 1'b0;
    cyc(3);
  endtask

  int vv_start;

  initial begin
    reset = 1'b1;
    a_irq = '0; a_level = 0; a_auto = 0; a_rot = 0; a_mask_we = 0; a_mask_wdata = '0;
    a_eoi_valid = 0; a_eoi_spec = 0; a_eoi_level = '0; a_inta = 0; a_base = 5'h14;
    b_irq = '0; b_mask_wdata = '0; b_eoi_valid = 0; b_eoi_spec = 0; b_eoi_level = '0;
    b_inta = 0; b_base = 4'hC;
    cyc(2);
    chk("rst_int_out", 32'(a_int_out), 32'h0);
    chk("rst_vv", 32'(a_vv), 32'h0);
    chk("rst_vector", 32'(a_vector), 32'h0);
    chk("rst_irr", 32'(a_irr_q), 32'h0);
    chk("rst_isr", 32'(a_isr_q), 32'h0);
    chk("rst_mask", 32'(a_mask_q), 32'h0);
    reset = 1'b0;
    cyc(1);

    // 1: edge capture latency, ack, non-specific EOI
    a_irq = 8'h08;
    cyc(1);
    a_irq = 8'h00;
    chk("t1_irr_set", 32'(a_irr_q), 32'h08);
    chk("t1_int_lat1", 32'(a_int_out), 32'h0);
    cyc(1);
    chk("t1_int_lat2", 32'(a_int_out), 32'h1);
    a_ack(8'hA3);
    chk("t1_isr", 32'(a_isr_q), 32'h08);
    chk("t1_irr", 32'(a_irr_q), 32'h00);
    a_eoi(1'b0, 3'd0);
    chk("t1_isr_eoi", 32'(a_isr_q), 32'h00);

    // 2: fully nested priority
    a_pulse(8'h24);
    chk("t2_irr", 32'(a_irr_q), 32'h24);
    chk("t2_int", 32'(a_int_out), 32'h1);
    a_ack(8'hA2);
    chk("t2_isr", 32'(a_isr_q), 32'h04);
    chk("t2_nested_block", 32'(a_int_out), 32'h0);
    a_eoi(1'b0, 3'd0);
    chk("t2_int_after_eoi", 32'(a_int_out), 32'h1);
    a_ack(8'hA5);
    chk("t2_isr5", 32'(a_isr_q), 32'h20);
    a_eoi(1'b0, 3'd0);

    // 3: rotation on EOI
    a_rot = 1'b1;
    a_pulse(8'h01);
    a_ack(8'hA0);
    a_pulse(8'h03);
    chk("t3_blocked", 32'(a_int_out), 32'h0);
    a_eoi(1'b0, 3'd0);
    chk("t3_int", 32'(a_int_out), 32'h1);
    a_ack(8'hA1);
    chk("t3_isr", 32'(a_isr_q), 32'h02);
    a_eoi(1'b0, 3'd0);
    a_ack(8'hA0);
    a_eoi(1'b0, 3'd0);
    a_rot = 1'b0;
    do_reset();

    // 4: level mode, request withdrawn before inta -> spurious
    a_level = 1'b1;
    a_irq = 8'h10;
    cyc(1);
    chk("t4_irr", 32'(a_irr_q), 32'h10);
    cyc(1);
    chk("t4_int", 32'(a_int_out), 32'h1);
    a_irq = 8'h00;
    cyc(1);
    chk("t4_irr_drop", 32'(a_irr_q), 32'h00);
    cyc(1);
    chk("t4_int_drop", 32'(a_int_out), 32'h0);
    a_ack(8'hA7);
    chk("t4_isr", 32'(a_isr_q), 32'h00);
    a_level = 1'b0;
    do_reset();

    // 5: auto EOI, long inta, auto rotation on ack
    a_auto = 1'b1;
    a_pulse(8'hC0);
    chk("t5_int", 32'(a_int_out), 32'h1);
    vv_start = vv_a_cnt;
    qa.push_back(8'hA6);
    a_inta = 1'b1;
    cyc(5);
    a_inta = 1'b0;
    cyc(3);
    chk("t5_one_pulse", 32'(vv_a_cnt - vv_start), 32'd1);
    chk("t5_isr", 32'(a_isr_q), 32'h00);
    chk("t5_irr", 32'(a_irr_q), 32'h80);
    chk("t5_int_again", 32'(a_int_out), 32'h1);
    a_ack(8'hA7);
    a_rot = 1'b1;
    a_pulse(8'h81);
    a_ack(8'hA0);
    a_pulse(8'h01);
    a_ack(8'hA7);
    a_ack(8'hA0);
    chk("t5_irr_done", 32'(a_irr_q), 32'h00);
    a_auto = 1'b0;
    a_rot = 1'b0;
    do_reset();

    // 6: EOI with ack, specific EOI, mask timing, reset during HOLD
    a_pulse(8'h08);
    a_ack(8'hA3);
    a_pulse(8'h02);
    chk("t6_int", 32'(a_int_out), 32'h1);
    qa.push_back(8'hA1);
    a_inta = 1'b1;
    a_eoi_valid = 1'b1;
    a_eoi_spec = 1'b0;
    cyc(1);
    a_inta = 1'b0;
    a_eoi_valid = 1'b0;
    cyc(3);
    chk("t6_eoi_ack_isr", 32'(a_isr_q), 32'h02);
    a_eoi(1'b1, 3'd5);
    chk("t6_eoi_noop", 32'(a_isr_q), 32'h02);
    a_eoi(1'b1, 3'd1);
    chk("t6_eoi_spec", 32'(a_isr_q), 32'h00);
    a_pulse(8'h10);
    qa.push_back(8'hA4);
    a_mask_we = 1'b1;
    a_mask_wdata = 8'h10;
    a_inta = 1'b1;
    cyc(1);
    a_mask_we = 1'b0;
    a_inta = 1'b0;
    cyc(3);
    chk("t6_mask", 32'(a_mask_q), 32'h10);
    chk("t6_old_mask_ack", 32'(a_isr_q), 32'h10);
    a_eoi(1'b0, 3'd0);
    a_pulse(8'h10);
    chk("t6_masked_irr", 32'(a_irr_q), 32'h10);
    chk("t6_masked_int", 32'(a_int_out), 32'h0);
    a_mask_we = 1'b1;
    a_mask_wdata = 8'h80;
    cyc(1);
    a_mask_we = 1'b0;
    cyc(1);
    chk("t6_unmask_int", 32'(a_int_out), 32'h1);
    qa.push_back(8'hA4);
    a_inta = 1'b1;
    cyc(2);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_int", 32'(a_int_out), 32'h0);
    chk("t6_async_vec", 32'(a_vector), 32'h0);
    chk("t6_async_isr", 32'(a_isr_q), 32'h0);
    chk("t6_async_mask", 32'(a_mask_q), 32'h0);
    qa.push_back(8'hA7);
    @(negedge clk);
    reset = 1'b0;
    cyc(1);
    a_inta = 1'b0;
    cyc(3);
    chk("t6_post_rst_isr", 32'(a_isr_q), 32'h0);

    // 16-line instance
    b_pulse(16'h0800);
    chk("b_irr", 32'(b_irr_q), 32'h0800);
    chk("b_int", 32'(b_int_out), 32'h1);
    b_ack(8'hCB);
    chk("b_isr", 32'(b_isr_q), 32'h0800);
    b_eoi_valid = 1'b1;
    b_eoi_spec = 1'b1;
    b_eoi_level = 4'd11;
    cyc(1);
    b_eoi_valid = 1'b0;
    cyc(1);
    chk("b_isr_eoi", 32'(b_isr_q), 32'h0000);
    b_pulse(16'h8004);
    b_ack(8'hC2);
    chk("b_isr2", 32'(b_isr_q), 32'h0004);
    b_eoi_valid = 1'b1;
    b_eoi_spec = 1'b0;
    cyc(1);
    b_eoi_valid = 1'b0;
    cyc(1);
    b_ack(8'hCF);
    chk("b_isr15", 32'(b_isr_q), 32'h8000);
    b_eoi_valid = 1'b1;
    cyc(1);
    b_eoi_valid = 1'b0;
    cyc(1);
    b_ack(8'hCF);
    chk("b_spurious_isr", 32'(b_isr_q), 32'h0000);

    cyc(2);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
